reg_wb_sel: RTL and testbench

REG_WB_SEL -- requirements
Module: reg_wb_sel

---
 rtl/reg_wb_sel.sv | 123 ++++++++++++
 tb/tb_reg_wb_sel.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_wb_sel.sv
// reg_wb_sel: write-back source selector for a small register file.
// It picks one of four sources (ALU result, decoder literal, memory data or
// link PC), waits for memory data when it has to, and then issues a
// one-cycle write on the register-file port.
//
// Optional feature: define REG_WB_FWD_EN to add a read-port bypass. The
// bypass returns the value being written in the current WRITE cycle when
// the read address matches the write address. Without the macro the bypass
// ports and their logic do not exist.
module reg_wb_sel #(
  parameter int DataWidth   = 8,
  parameter int RegAdrWidth = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_req,
  input  logic [1:0]             wb_src,
  input  logic [RegAdrWidth-1:0] wb_dst,
  input  logic [DataWidth-1:0]   result,
  input  logic [DataWidth-1:0]   literal_adr,
  input  logic [DataWidth-1:0]   mem_data,
  input  logic [DataWidth-1:0]   pc_link,
  input  logic                   mem_ready,
`ifdef REG_WB_FWD_EN
  input  logic [RegAdrWidth-1:0] rd_adr,
  input  logic [DataWidth-1:0]   rd_val_in,
  output logic [DataWidth-1:0]   rd_val,
  output logic                   fwd_hit,
`endif
  output logic                   busy,
  output logic                   reg_we,
  output logic [RegAdrWidth-1:0] reg_adr,
  output logic [DataWidth-1:0]   reg_val
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LIT = 2'd1;
  localparam logic [1:0] SRC_MEM = 2'd2;
  localparam logic [1:0] SRC_PC  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [RegAdrWidth-1:0] adr_q, adr_d;
  logic [DataWidth-1:0]   val_q, val_d;
  logic [DataWidth-1:0]   src_val;

  // Value selected for the immediate sources. Memory is captured later,
  // when mem_ready arrives.
  always_comb begin
    case (wb_src)
      SRC_ALU: src_val = result;
      SRC_LIT: src_val = literal_adr;
      SRC_PC:  src_val = pc_link;
      default: src_val = result;
    endcase
  end

  // Next-state and capture logic. WRITE accepts a new request exactly like
  // IDLE does, so back-to-back requests produce one write per cycle.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    adr_d   = adr_q;
    val_d   = val_q;
    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (wb_req) begin
          adr_d = wb_dst;
          if (wb_src == SRC_MEM) begin
            // mem_ready in the request cycle is deliberately not looked at.
            state_d = WAIT_MEM;
          end else begin
            val_d   = src_val;
            state_d = WRITE;
          end
        end
      end
      WAIT_MEM: begin
        // Requests are ignored here; the requester must hold or reissue.
        if (mem_ready) begin
          val_d   = mem_data;
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured write data. Reset wins over every other input and
  // clears the captured address and data, which aborts any pending write.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      val_q   <= val_d;
    end
  end

  assign busy    = (state_q == WAIT_MEM);
  assign reg_we  = (state_q == WRITE);
  assign reg_adr = adr_q;
  assign reg_val = val_q;

`ifdef REG_WB_FWD_EN
  // Bypass: a read of the register being written this cycle sees the new value.
  always_comb begin
    fwd_hit = (state_q == WRITE) && (rd_adr == adr_q);
    rd_val  = fwd_hit ? val_q : rd_val_in;
  end
`endif

endmodule

// File: tb/tb_reg_wb_sel.sv
// Directed testbench for reg_wb_sel. Inputs change 1 time unit after a
// rising edge and outputs are checked at that same point, away from the edge.
// The bypass checks are compiled only when REG_WB_FWD_EN is defined.
module tb_reg_wb_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic       wb_req;
  logic [1:0] wb_src;
  logic [2:0] wb_dst;
  logic [7:0] result, literal_adr, mem_data, pc_link;
  logic       mem_ready;
  logic       busy, reg_we;
  logic [2:0] reg_adr;
  logic [7:0] reg_val;
`ifdef REG_WB_FWD_EN
  logic [2:0] rd_adr;
  logic [7:0] rd_val_in, rd_val;
  logic       fwd_hit;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_wb_sel #(.DataWidth(8), .RegAdrWidth(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_req     (wb_req),
    .wb_src     (wb_src),
    .wb_dst     (wb_dst),
    .result     (result),
    .literal_adr(literal_adr),
    .mem_data   (mem_data),
    .pc_link    (pc_link),
    .mem_ready  (mem_ready),
`ifdef REG_WB_FWD_EN
    .rd_adr     (rd_adr),
    .rd_val_in  (rd_val_in),
    .rd_val     (rd_val),
    .fwd_hit    (fwd_hit),
`endif
    .busy       (busy),
    .reg_we     (reg_we),
    .reg_adr    (reg_adr),
    .reg_val    (reg_val)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [2:0] adr,
                            input logic [7:0] val, input logic bsy);
    check({tag, ".reg_we"},  reg_we,  we);
    check({tag, ".reg_adr"}, reg_adr, adr);
    check({tag, ".reg_val"}, reg_val, val);
    check({tag, ".busy"},    busy,    bsy);
  endtask

  initial begin
    reset = 1'b1; wb_req = 1'b0; wb_src = 2'd0; wb_dst = 3'd0;
    result = 8'h00; literal_adr = 8'h00; mem_data = 8'h00; pc_link = 8'h00;
    mem_ready = 1'b0;
`ifdef REG_WB_FWD_EN
    rd_adr = 3'd0; rd_val_in = 8'h00;
`endif
    tick(); tick();
    reset = 1'b0;
    check_port("reset", 1'b0, 3'd0, 8'h00, 1'b0);

    // ALU source: 44@2 one cycle after the request.
    wb_req = 1'b1; wb_src = 2'd0; result = 8'h44; wb_dst = 3'd2;
    tick();
    wb_req = 1'b0;
    check_port("alu", 1'b1, 3'd2, 8'h44, 1'b0);
    tick();
    check_port("alu_hold", 1'b0, 3'd2, 8'h44, 1'b0);

    // Literal then link, back to back: F3@5 then 10@6 with no gap.
    wb_req = 1'b1; wb_src = 2'd1; literal_adr = 8'hF3; wb_dst = 3'd5;
    tick();
    wb_src = 2'd3; pc_link = 8'h10; wb_dst = 3'd6;
    check_port("lit", 1'b1, 3'd5, 8'hF3, 1'b0);
    tick();
    wb_req = 1'b0;
    check_port("pc_b2b", 1'b1, 3'd6, 8'h10, 1'b0);
    tick();
    check_port("pc_end", 1'b0, 3'd6, 8'h10, 1'b0);

    // Memory source: mem_ready in the request cycle is ignored, busy for
    // three cycles, a request during busy is dropped, A5@1 after mem_ready.
    wb_req = 1'b1; wb_src = 2'd2; wb_dst = 3'd1; mem_ready = 1'b1; mem_data = 8'hEE;
    tick();
    wb_req = 1'b0; mem_ready = 1'b0;
    check("mem_busy1", busy, 1'b1);
    check("mem_we1", reg_we, 1'b0);
    wb_req = 1'b1; wb_src = 2'd0; result = 8'h77; wb_dst = 3'd7;
    tick();
    wb_req = 1'b0;
    check("mem_busy2", busy, 1'b1);
    tick();
    check("mem_busy3", busy, 1'b1);
    check("mem_we3", reg_we, 1'b0);
    mem_ready = 1'b1; mem_data = 8'hA5;
    tick();
    mem_ready = 1'b0;
    check_port("mem", 1'b1, 3'd1, 8'hA5, 1'b0);
    tick();
    check_port("mem_end", 1'b0, 3'd1, 8'hA5, 1'b0);

    // Reset in WAIT_MEM with mem_ready high: write aborted, outputs cleared.
    wb_req = 1'b1; wb_src = 2'd2; wb_dst = 3'd3;
    tick();
    wb_req = 1'b0;
    check("rstwait_busy", busy, 1'b1);
    reset = 1'b1; mem_ready = 1'b1; mem_data = 8'h5A;
    tick();
    reset = 1'b0;
    check_port("rstwait", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    mem_ready = 1'b0;
    check_port("rstwait_after", 1'b0, 3'd0, 8'h00, 1'b0);

    // Address 0 is an ordinary destination.
    wb_req = 1'b1; wb_src = 2'd0; result = 8'h99; wb_dst = 3'd0;
    tick();
    wb_req = 1'b0;
    check_port("adr0", 1'b1, 3'd0, 8'h99, 1'b0);

    // Reset arriving while a new request is made from WRITE takes priority.
    wb_req = 1'b1; wb_src = 2'd0; result = 8'h12; wb_dst = 3'd4; reset = 1'b1;
    tick();
    wb_req = 1'b0; reset = 1'b0;
    check_port("rstwrite", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    check("rstwrite_after", reg_we, 1'b0);

`ifdef REG_WB_FWD_EN
    // Bypass: 3C@4, read of 4 hits, read of 3 falls through to rd_val_in.
    wb_req = 1'b1; wb_src = 2'd0; result = 8'h3C; wb_dst = 3'd4;
    rd_adr = 3'd4; rd_val_in = 8'h11;
    tick();
    wb_req = 1'b0;
    check("fwd_hit4", fwd_hit, 1'b1);
    check("fwd_val4", rd_val, 8'h3C);
    rd_adr = 3'd3;
    #1;
    check("fwd_hit3", fwd_hit, 1'b0);
    check("fwd_val3", rd_val, 8'h11);
    rd_adr = 3'd4;
    tick();
    check("fwd_idle_hit", fwd_hit, 1'b0);
    check("fwd_idle_val", rd_val, 8'h11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
